// File: rtl/l1i_responder.sv
// Direct-mapped L1 instruction cache: returns the full line for each fetch address and refills from memory on a miss.
// Latency: hit = 1 cycle after accept; miss = memory latency + 2 cycles.
// Backpressure: req_ready_out is low while a request is in flight; the response is never stalled; the refill request is held until accepted.
module l1i_responder #(
    parameter int CACHE_LINE_WIDTH = 64,
    parameter int NUM_SETS         = 16,
    parameter int ADDR_WIDTH       = 64
) (
    input  logic                                clk_in,
    input  logic                                rst_N_in,
    input  logic                                req_valid_in,
    input  logic [ADDR_WIDTH-1:0]               req_addr_in,
    output logic                                req_ready_out,
    input  logic                                flush_in,
    output logic                                l1i_valid_out,
    output logic [ADDR_WIDTH-1:0]               l1i_addr_out,
    output logic [CACHE_LINE_WIDTH-1:0][7:0]    l1i_cacheline_out,
    output logic                                mem_req_valid_out,
    input  logic                                mem_req_ready_in,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr_out,
    input  logic                                mem_resp_valid_in,
    input  logic [CACHE_LINE_WIDTH-1:0][7:0]    mem_resp_data_in
);

    localparam int OFF  = $clog2(CACHE_LINE_WIDTH);
    localparam int IDX  = $clog2(NUM_SETS);
    localparam int TAGW = ADDR_WIDTH - OFF - IDX;

    typedef logic [CACHE_LINE_WIDTH-1:0][7:0] line_t;
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESP      = 2'd1,
        S_MISS_REQ  = 2'd2,
        S_MISS_WAIT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  squash_q, squash_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    line_t                 line_q, line_d;

    logic [TAGW-1:0] tag_mem  [NUM_SETS];
    line_t           data_mem [NUM_SETS];

    logic [IDX-1:0]  req_idx, fill_idx;
    logic [TAGW-1:0] req_tag, fill_tag;
    logic            hit, accept, fill;

    assign req_idx  = req_addr_in[OFF+IDX-1:OFF];
    assign req_tag  = req_addr_in[ADDR_WIDTH-1:OFF+IDX];
    assign fill_idx = addr_q[OFF+IDX-1:OFF];
    assign fill_tag = addr_q[ADDR_WIDTH-1:OFF+IDX];
    assign hit      = valid_q[req_idx] & (tag_mem[req_idx] == req_tag);
    assign accept   = req_valid_in & req_ready_out;
    assign fill     = (state_q == S_MISS_WAIT) & mem_resp_valid_in;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            squash_q <= 1'b0;
            valid_q  <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            squash_q <= squash_d;
            valid_q  <= valid_d;
            line_q   <= line_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_resp_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = hit ? S_RESP : S_MISS_REQ;
            S_RESP:      state_d = S_IDLE;
            S_MISS_REQ:  if (mem_req_ready_in) state_d = S_MISS_WAIT;
            S_MISS_WAIT: if (mem_resp_valid_in) state_d = (squash_q | flush_in) ? S_IDLE : S_RESP;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = accept ? req_addr_in : addr_q;
        line_d   = line_q;
        valid_d  = valid_q;
        squash_d = squash_q;
        if (accept && hit) begin
            line_d = data_mem[req_idx];
        end
        if (fill) begin
            line_d            = mem_resp_data_in;
            valid_d[fill_idx] = 1'b1;
        end
        // The refill must still complete after a flush; only its response is dropped.
        if (((state_q == S_MISS_REQ) || (state_q == S_MISS_WAIT)) && flush_in) begin
            squash_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            squash_d = 1'b0;
        end
    end

    always_comb begin
        req_ready_out     = rst_N_in & (state_q == S_IDLE) & ~flush_in;
        l1i_valid_out     = (state_q == S_RESP) & ~flush_in;
        l1i_addr_out      = '0;
        l1i_cacheline_out = '0;
        mem_req_valid_out = (state_q == S_MISS_REQ);
        mem_req_addr_out  = '0;
        if (l1i_valid_out) begin
            l1i_addr_out      = addr_q;
            l1i_cacheline_out = line_q;
        end
        if (mem_req_valid_out) begin
            mem_req_addr_out = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        end
    end

endmodule

// File: tb/tb_l1i_responder.sv
// Bench for l1i_responder: directed scenarios followed by randomized fetches against a set/tag model.
module tb_l1i_responder;

    logic                clk_in = 1'b0;
    logic                rst_N_in;
    logic                req_valid_in;
    logic [63:0]         req_addr_in;
    logic                req_ready_out;
    logic                flush_in;
    logic                l1i_valid_out;
    logic [63:0]         l1i_addr_out;
    logic [63:0][7:0]    l1i_cacheline_out;
    logic                mem_req_valid_out;
    logic                mem_req_ready_in;
    logic [63:0]         mem_req_addr_out;
    logic                mem_resp_valid_in;
    logic [63:0][7:0]    mem_resp_data_in;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_valid [16];
    logic [53:0] m_tag   [16];

    always #5 clk_in = ~clk_in;

    l1i_responder dut (
        .clk_in            (clk_in),
        .rst_N_in          (rst_N_in),
        .req_valid_in      (req_valid_in),
        .req_addr_in       (req_addr_in),
        .req_ready_out     (req_ready_out),
        .flush_in          (flush_in),
        .l1i_valid_out     (l1i_valid_out),
        .l1i_addr_out      (l1i_addr_out),
        .l1i_cacheline_out (l1i_cacheline_out),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Backing memory contents: a pure function of the line address (line 0x1000 holds byte i = i).
    function automatic logic [511:0] mem_line(input logic [63:0] a);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(i) ^ a[13:6] ^ a[21:14] ^ a[63:56] ^ 8'h40;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input int rdy_dly, input int resp_dly,
                         input bit fl_wait, input bit fl_resp,
                         output logic [511:0] line_obs, output bit miss_obs);
        int           idx;
        logic [53:0]  tg;
        bit           exp_hit;
        bit           squashed;
        logic [511:0] exp_line;
        logic [63:0]  exp_maddr;
        idx       = int'(a[9:6]);
        tg        = a[63:10];
        exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
        exp_line  = mem_line(a);
        exp_maddr = {a[63:6], 6'd0};
        line_obs  = '0;

        req_valid_in = 1'b1;
        req_addr_in  = a;
        #1;
        chk("req_ready_idle", 512'(req_ready_out), 512'(1));
        tick();
        req_valid_in = 1'b0;
        req_addr_in  = {$urandom, $urandom};
        miss_obs = mem_req_valid_out;
        chk("miss_detect", 512'(mem_req_valid_out), 512'(!exp_hit));
        chk("req_ready_busy", 512'(req_ready_out), 512'(0));

        if (exp_hit) begin
            if (fl_resp) begin
                flush_in = 1'b1;
                #1;
                chk("flush_resp_vld", 512'(l1i_valid_out), 512'(0));
            end else begin
                chk("hit_vld", 512'(l1i_valid_out), 512'(1));
                chk("hit_addr", 512'(l1i_addr_out), 512'(a));
                chk("hit_line", l1i_cacheline_out, exp_line);
            end
            line_obs = l1i_cacheline_out;
            tick();
            flush_in = 1'b0;
            chk("hit_single_pulse", 512'(l1i_valid_out), 512'(0));
        end else begin
            chk("mreq_addr", 512'(mem_req_addr_out), 512'(exp_maddr));
            chk("miss_no_vld", 512'(l1i_valid_out), 512'(0));
            for (int i = 0; i < rdy_dly; i++) begin
                tick();
                chk("mreq_hold_vld", 512'(mem_req_valid_out), 512'(1));
                chk("mreq_hold_addr", 512'(mem_req_addr_out), 512'(exp_maddr));
                chk("mreq_hold_rdy", 512'(req_ready_out), 512'(0));
            end
            mem_req_ready_in = 1'b1;
            tick();
            mem_req_ready_in = 1'b0;
            chk("mreq_dropped", 512'(mem_req_valid_out), 512'(0));
            for (int i = 0; i < resp_dly; i++) begin
                if (fl_wait && i == 0) flush_in = 1'b1;
                tick();
                flush_in = 1'b0;
                chk("wait_no_vld", 512'(l1i_valid_out), 512'(0));
                chk("wait_rdy", 512'(req_ready_out), 512'(0));
            end
            mem_resp_valid_in = 1'b1;
            mem_resp_data_in  = exp_line;
            tick();
            mem_resp_valid_in = 1'b0;
            mem_resp_data_in  = {16{$urandom}};
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            squashed = fl_wait && (resp_dly > 0);
            chk("miss_vld", 512'(l1i_valid_out), 512'(!squashed));
            if (!squashed) begin
                chk("miss_addr", 512'(l1i_addr_out), 512'(a));
                chk("miss_line", l1i_cacheline_out, exp_line);
            end
            line_obs = l1i_cacheline_out;
            tick();
            chk("miss_single_pulse", 512'(l1i_valid_out), 512'(0));
        end
    endtask

    initial begin
        logic [511:0] ln;
        bit           ms;
        logic [63:0]  a;
        int           rd, rs;
        bit           fw, fr;

        rst_N_in          = 1'b0;
        req_valid_in      = 1'b0;
        req_addr_in       = '0;
        flush_in          = 1'b0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        model_clear();
        tick();
        chk("rst_req_ready", 512'(req_ready_out), 512'(0));
        chk("rst_l1i_vld", 512'(l1i_valid_out), 512'(0));
        chk("rst_mreq_vld", 512'(mem_req_valid_out), 512'(0));
        chk("rst_mreq_addr", 512'(mem_req_addr_out), 512'(0));
        chk("rst_l1i_line", l1i_cacheline_out, 512'(0));
        tick();
        rst_N_in = 1'b1;
        #1;
        chk("post_rst_ready", 512'(req_ready_out), 512'(1));

        // Cold miss on 0x1010.
        fetch(64'h1010, 2, 3, 1'b0, 1'b0, ln, ms);
        chk("t1_miss", 512'(ms), 512'(1));
        chk("t1_byte5", 512'(ln[5*8 +: 8]), 512'(8'h05));

        // Hit in the same line.
        fetch(64'h1038, 0, 0, 1'b0, 1'b0, ln, ms);
        chk("t2_hit", 512'(ms), 512'(0));

        // Conflict on the same index evicts 0x1000.
        fetch(64'h1400, 1, 1, 1'b0, 1'b0, ln, ms);
        chk("t3_miss_a", 512'(ms), 512'(1));
        fetch(64'h1000, 0, 2, 1'b0, 1'b0, ln, ms);
        chk("t3_miss_b", 512'(ms), 512'(1));

        // Flush during the refill wait: no response but the line is installed.
        fetch(64'h3080, 0, 2, 1'b1, 1'b0, ln, ms);
        fetch(64'h30A4, 0, 0, 1'b0, 1'b0, ln, ms);
        chk("t4_hit_after_flush", 512'(ms), 512'(0));

        // Memory request backpressure.
        fetch(64'h5100, 5, 1, 1'b0, 1'b0, ln, ms);

        // Flush in RESP suppresses the pulse; flush in IDLE blocks acceptance.
        fetch(64'h5104, 0, 0, 1'b0, 1'b1, ln, ms);
        flush_in     = 1'b1;
        req_valid_in = 1'b1;
        req_addr_in  = 64'h9000;
        #1;
        chk("flush_idle_rdy", 512'(req_ready_out), 512'(0));
        tick();
        flush_in     = 1'b0;
        req_valid_in = 1'b0;
        chk("flush_idle_no_mreq", 512'(mem_req_valid_out), 512'(0));
        chk("flush_idle_no_vld", 512'(l1i_valid_out), 512'(0));

        // Reset in MISS_WAIT, then a stale response.
        req_valid_in = 1'b1;
        req_addr_in  = 64'h2040;
        tick();
        req_valid_in     = 1'b0;
        mem_req_ready_in = 1'b1;
        tick();
        mem_req_ready_in = 1'b0;
        tick();
        rst_N_in = 1'b0;
        #1;
        chk("t6_rst_mreq", 512'(mem_req_valid_out), 512'(0));
        chk("t6_rst_vld", 512'(l1i_valid_out), 512'(0));
        chk("t6_rst_rdy", 512'(req_ready_out), 512'(0));
        model_clear();
        tick();
        rst_N_in          = 1'b1;
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = mem_line(64'h2040);
        tick();
        mem_resp_valid_in = 1'b0;
        chk("t6_stale_vld", 512'(l1i_valid_out), 512'(0));
        chk("t6_stale_rdy", 512'(req_ready_out), 512'(1));
        fetch(64'h1000, 0, 1, 1'b0, 1'b0, ln, ms);
        chk("t6_refetch_miss", 512'(ms), 512'(1));
        fetch(64'h2040, 0, 1, 1'b0, 1'b0, ln, ms);
        chk("t6_stale_not_installed", 512'(ms), 512'(1));

        // Random fetches over a small tag/index pool so hits, conflicts and flushes all occur.
        for (int n = 0; n < 200; n++) begin
            a        = '0;
            a[11:10] = 2'($urandom_range(0, 3));
            a[9:6]   = 4'($urandom_range(0, 7));
            a[5:0]   = 6'($urandom);
            if ($urandom_range(0, 7) == 0) a[63] = 1'b1;
            rd = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            fw = ($urandom_range(0, 7) == 0);
            fr = ($urandom_range(0, 7) == 0);
            fetch(a, rd, rs, fw, fr, ln, ms);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
